// File: rtl/tap_buffer_pkg.sv
// tap_buffer_pkg: shared helpers for the programmable delay line.
// Holds the tap-select width helper and the tap clamp function.
// Optional feature macro used by the top: TAP_BUFFER_FILL_EN.
package tap_buffer_pkg;

   // Width of a tap selector that can address bypass plus stages 1..depth.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Taps beyond the last stage collapse onto the last stage.
   function automatic int clamp_sel(input int sel, input int depth);
      return (sel > depth) ? depth : sel;
   endfunction

endpackage

// File: rtl/tap_buffer_stage.sv
// tap_buffer_stage: one W-bit pipeline register (valid bit packed in by the caller).
// Latency: 1 enabled edge. Backpressure: en=0 holds contents; flush clears regardless of en.
// Reset is asynchronous and active-high.
module tap_buffer_stage #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Stage register: reset > flush > enable > hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (flush) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/tap_buffer.sv
// tap_buffer: DEPTH-stage delay line of WIDTH-bit words with per-stage valids and a runtime tap.
// Latency: sel cycles of enabled edges (sel=0 is a combinational bypass). Backpressure: en=0 stalls all stages.
// Optional occupancy counter and fill port under TAP_BUFFER_FILL_EN.
module tap_buffer
   import tap_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int SW    = sel_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic [SW-1:0]    sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
`ifdef TAP_BUFFER_FILL_EN
   ,
   output logic [SW-1:0]    fill
`endif
);

   // Tap 0 is the live input; tap k is the output of stage k. Each entry is {valid, data}.
   logic [WIDTH:0] w_tap [0:DEPTH];
   logic [SW-1:0]  w_idx;

   assign w_tap[0] = {in_valid, in};

   genvar g;
   generate
      for (g = 1; g <= DEPTH; g++) begin : g_stage
         tap_buffer_stage #(
            .W (WIDTH + 1)
         ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .en    (en),
            .i_d   (w_tap[g-1]),
            .o_q   (w_tap[g])
         );
      end
   endgenerate

   // Out-of-range selectors read the last stage rather than wrapping or returning X.
   assign w_idx = SW'(clamp_sel(int'(sel), DEPTH));

   assign {out_valid, out} = w_tap[w_idx];

`ifdef TAP_BUFFER_FILL_EN
   logic [SW-1:0] r_fill;
   logic          w_last_vld;

   assign w_last_vld = w_tap[DEPTH][WIDTH];

   // Occupancy tracks valid words entering stage 1 minus the one leaving the last stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fill <= '0;
      end else if (flush) begin
         r_fill <= '0;
      end else if (en) begin
         r_fill <= r_fill + SW'(in_valid) - SW'(w_last_vld);
      end
   end

   assign fill = r_fill;
`endif

endmodule

// File: tb/tb_tap_buffer.sv
// tb_tap_buffer: directed plus randomized checks of tap_buffer (WIDTH=8, DEPTH=4).
// Reference model: history of words accepted on enabled edges; tap k is the k-th newest.
// Fill checks are active when TAP_BUFFER_FILL_EN is defined.
module tb_tap_buffer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             en;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_dat;
   logic [SW-1:0]    sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
`ifdef TAP_BUFFER_FILL_EN
   logic [SW-1:0]    fill;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Newest accepted entry at index 0, each entry {valid, data}.
   logic [WIDTH:0] hist[$];

   tap_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in        (in_dat),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid)
`ifdef TAP_BUFFER_FILL_EN
      ,
      .fill      (fill)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH:0] model_tap(input int s);
      int k;
      if (s == 0) return {in_valid, in_dat};
      k = (s > DEPTH) ? DEPTH : s;
      if (k <= hist.size()) return hist[k-1];
      return '0;
   endfunction

   function automatic int model_fill();
      int c = 0;
      foreach (hist[i]) if (hist[i][WIDTH]) c++;
      return c;
   endfunction

   // One clock edge: the model applies the inputs that were stable across the edge.
   task automatic tick();
      @(posedge clk);
      if (reset || flush) begin
         hist.delete();
      end else if (en) begin
         hist.push_front({in_valid, in_dat});
         if (hist.size() > DEPTH) void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic check_out(input string tag);
      chk(tag, 16'({out_valid, out}), 16'(model_tap(int'(sel))));
`ifdef TAP_BUFFER_FILL_EN
      chk({tag, "_fill"}, 16'(fill), 16'(model_fill()));
`endif
   endtask

   task automatic push(input logic v, input logic [WIDTH-1:0] d);
      in_valid = v;
      in_dat   = d;
      en       = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dat = '0; sel = 3'd2;
      #1;
      // Reset with sel=2: input activity must not reach the tap.
      in_dat = 8'hA5; in_valid = 1'b1; en = 1'b1;
      #1;
      chk("rst_sel2", 16'({out_valid, out}), 16'h0000);
      tick();
      chk("rst_sel2_edge", 16'({out_valid, out}), 16'h0000);
      check_out("rst_model");
      sel = 3'd0; #1;
      chk("rst_bypass", 16'({out_valid, out}), 16'h01A5);
      reset = 1'b0; en = 1'b0; in_valid = 1'b0; in_dat = '0;
      tick();
      sel = 3'd4; #1;
      chk("post_rst_tap4", 16'({out_valid, out}), 16'h0000);

      // Delay check at tap 3.
      sel = 3'd3;
      push(1'b1, 8'h11); check_out("dly_e1");
      push(1'b1, 8'h22); check_out("dly_e2");
      push(1'b1, 8'h33);
      chk("dly_e3", 16'({out_valid, out}), 16'h0111);

      // Stall: tap 4 holds the oldest word while en=0.
      push(1'b1, 8'h44);
      sel = 3'd4; #1;
      chk("stall_pre", 16'({out_valid, out}), 16'h0111);
      en = 1'b0; in_dat = 8'h99;
      tick(); chk("stall_c1", 16'({out_valid, out}), 16'h0111);
      tick(); chk("stall_c2", 16'({out_valid, out}), 16'h0111);
      push(1'b1, 8'h55);
      chk("stall_resume", 16'({out_valid, out}), 16'h0122);
`ifdef TAP_BUFFER_FILL_EN
      chk("full_fill", 16'(fill), 16'd4);
`endif

      // Flush together with en: buffer empty afterwards.
      flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_dat = 8'h77;
      tick();
      flush = 1'b0; en = 1'b0;
      for (int s = 1; s <= DEPTH; s++) begin
         sel = SW'(s); #1;
         chk($sformatf("flush_tap%0d", s), 16'({out_valid, out}), 16'h0000);
      end
`ifdef TAP_BUFFER_FILL_EN
      chk("flush_fill", 16'(fill), 16'd0);
`endif

      // Tap sweep and clamp over a static fill of 01..04.
      for (int i = 1; i <= DEPTH; i++) push(1'b1, 8'(i));
      en = 1'b0; in_dat = 8'h5A; in_valid = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel = SW'(s); #1;
         check_out($sformatf("sweep_sel%0d", s));
      end
      sel = 3'd0; #1; chk("sweep_bypass", 16'({out_valid, out}), 16'h005A);
      sel = 3'd1; #1; chk("sweep_tap1", 16'({out_valid, out}), 16'h0104);
      sel = 3'd7; #1; chk("sweep_clamp7", 16'({out_valid, out}), 16'h0101);

`ifdef TAP_BUFFER_FILL_EN
      // Fill ramp with in_valid pattern 1,0,1,1 then drain.
      flush = 1'b1; tick(); flush = 1'b0;
      push(1'b1, 8'hB1); chk("fill_r1", 16'(fill), 16'd1);
      push(1'b0, 8'hB2); chk("fill_r2", 16'(fill), 16'd1);
      push(1'b1, 8'hB3); chk("fill_r3", 16'(fill), 16'd2);
      push(1'b1, 8'hB4); chk("fill_r4", 16'(fill), 16'd3);
      push(1'b0, 8'hB5); chk("fill_d1", 16'(fill), 16'd2);
      push(1'b0, 8'hB6); chk("fill_d2", 16'(fill), 16'd2);
      push(1'b0, 8'hB7); chk("fill_d3", 16'(fill), 16'd1);
`endif

      // Randomized traffic with occasional stalls, flushes and mid-stream resets.
      for (int n = 0; n < 400; n++) begin
         en       = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         in_valid = $urandom_range(0, 1) != 0;
         in_dat   = 8'($urandom);
         sel      = SW'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b1;
            hist.delete();
            #1;
            check_out("rnd_rst_async");
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
         check_out("rnd_edge");
         sel = SW'($urandom_range(0, 7));
         in_dat = 8'($urandom);
         #1;
         check_out("rnd_selchg");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
